// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: round-robin sequencer sharing one SPI shift engine.
// Loads the engine, frames slave selects, starts and supervises transfers.
module spi_xfer_ctrl #(
    parameter int NREQ     = 2,
    parameter int SS_W     = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int WD_CYC   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*32-1:0]   i_req_data,
    input  logic [NREQ*5-1:0]    i_req_len,
    input  logic [NREQ*SS_W-1:0] i_req_ss,
    input  logic                 i_lsb,
    input  logic                 i_tip,
    input  logic [31:0]          i_eng_rdata,
    output logic [3:0]           o_latch,
    output logic [3:0]           o_byte_sel,
    output logic [31:0]          o_eng_wdata,
    output logic [4:0]           o_len,
    output logic                 o_lsb,
    output logic                 o_go,
    output logic [SS_W-1:0]      o_ss_n,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic [NREQ-1:0]      o_err,
    output logic [31:0]          o_rdata,
    output logic                 o_busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WD_CYC + 16) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, GO, WSTART, WDONE, CAPT, HOLD
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   own, own_nx;
    logic [IW-1:0]   idx, pick;
    logic            found;
    logic [31:0]     p_data;
    logic [4:0]      p_len;
    logic [SS_W-1:0] p_ss;

    logic [3:0]      latch_nx, bsel_nx;
    logic [31:0]     wdata_nx, rdata_nx;
    logic [4:0]      len_nx;
    logic            go_nx, busy_nx;
    logic [SS_W-1:0] ssn_nx;
    logic [NREQ-1:0] gnt_nx, done_nx, err_nx;

    assign o_lsb = i_lsb;

    // Round-robin search starting after the last owner, plus its request fields.
    always_comb begin
        found  = 1'b0;
        pick   = own;
        idx    = '0;
        p_data = '0;
        p_len  = '0;
        p_ss   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(own) + i) % NREQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == pick) begin
                p_data = i_req_data[k*32 +: 32];
                p_len  = i_req_len[k*5 +: 5];
                p_ss   = i_req_ss[k*SS_W +: SS_W];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        own_nx   = own;
        latch_nx = '0;
        bsel_nx  = '0;
        go_nx    = 1'b0;
        gnt_nx   = '0;
        done_nx  = '0;
        err_nx   = '0;
        wdata_nx = o_eng_wdata;
        len_nx   = o_len;
        ssn_nx   = o_ss_n;
        rdata_nx = o_rdata;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx = LOAD;
                    own_nx   = pick;
                    gnt_nx   = NREQ'(1) << pick;
                    latch_nx = 4'b0001;
                    bsel_nx  = 4'hF;
                    wdata_nx = p_data;
                    len_nx   = p_len;
                    ssn_nx   = ~p_ss;
                end
            end
            LOAD: begin
                state_nx = SETUP;
                cnt_nx   = '0;
            end
            SETUP: begin
                if (cnt == CW'(CS_SETUP - 1)) begin
                    state_nx = GO;
                    go_nx    = 1'b1;
                    cnt_nx   = '0;
                end
            end
            GO: begin
                state_nx = WSTART;
            end
            WSTART: begin
                if (i_tip) begin
                    state_nx = WDONE;
                end else if (cnt == CW'(WD_CYC - 1)) begin
                    state_nx = HOLD;
                    err_nx   = NREQ'(1) << own;
                    cnt_nx   = '0;
                end
            end
            WDONE: begin
                if (!i_tip) state_nx = CAPT;
            end
            CAPT: begin
                state_nx = HOLD;
                rdata_nx = i_eng_rdata;
                done_nx  = NREQ'(1) << own;
                cnt_nx   = '0;
            end
            HOLD: begin
                if (cnt == CW'(CS_HOLD)) begin
                    state_nx = IDLE;
                    ssn_nx   = '1;
                end
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // Registered outputs and transaction bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            own         <= IW'(NREQ - 1);
            o_latch     <= '0;
            o_byte_sel  <= '0;
            o_eng_wdata <= '0;
            o_len       <= '0;
            o_go        <= 1'b0;
            o_ss_n      <= '1;
            o_gnt       <= '0;
            o_done      <= '0;
            o_err       <= '0;
            o_rdata     <= '0;
            o_busy      <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            own         <= own_nx;
            o_latch     <= latch_nx;
            o_byte_sel  <= bsel_nx;
            o_eng_wdata <= wdata_nx;
            o_len       <= len_nx;
            o_go        <= go_nx;
            o_ss_n      <= ssn_nx;
            o_gnt       <= gnt_nx;
            o_done      <= done_nx;
            o_err       <= err_nx;
            o_rdata     <= rdata_nx;
            o_busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: table vectors, hand sequences and random transfers
// checked against a transaction-level model of the sequencer.
module tb_spi_xfer_ctrl;

    localparam int NREQ     = 2;
    localparam int SS_W     = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int WD_CYC   = 8;

    logic                 i_clk;
    logic                 i_rst_n;
    logic [NREQ-1:0]      i_req;
    logic [NREQ*32-1:0]   i_req_data;
    logic [NREQ*5-1:0]    i_req_len;
    logic [NREQ*SS_W-1:0] i_req_ss;
    logic                 i_lsb;
    logic                 i_tip;
    logic [31:0]          i_eng_rdata;
    logic [3:0]           o_latch;
    logic [3:0]           o_byte_sel;
    logic [31:0]          o_eng_wdata;
    logic [4:0]           o_len;
    logic                 o_lsb;
    logic                 o_go;
    logic [SS_W-1:0]      o_ss_n;
    logic [NREQ-1:0]      o_gnt;
    logic [NREQ-1:0]      o_done;
    logic [NREQ-1:0]      o_err;
    logic [31:0]          o_rdata;
    logic                 o_busy;

    spi_xfer_ctrl #(
        .NREQ(NREQ), .SS_W(SS_W), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .WD_CYC(WD_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_req_data(i_req_data), .i_req_len(i_req_len),
        .i_req_ss(i_req_ss), .i_lsb(i_lsb), .i_tip(i_tip),
        .i_eng_rdata(i_eng_rdata), .o_latch(o_latch),
        .o_byte_sel(o_byte_sel), .o_eng_wdata(o_eng_wdata),
        .o_len(o_len), .o_lsb(o_lsb), .o_go(o_go), .o_ss_n(o_ss_n),
        .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
        .o_rdata(o_rdata), .o_busy(o_busy)
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] d0, d1;
        logic [4:0]  l0, l1;
        logic [7:0]  s0, s1;
        int          dly;
        int          tl;
        logic [31:0] echo;
        int          exp_own;
        int          exp_err;
    } vec_t;

    int          n_vec;
    int          n_bad;
    int          m_last;
    logic [31:0] m_rdata;
    vec_t        tbl [11];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One whole transaction; the bench plays the engine.
    task automatic xfer(input vec_t v);
        int          own, k, c, gc, goc, dc, ec, rc;
        int          rise, fall, endc, ndone, nerr;
        bit          expe, ss_ok;
        logic [31:0] wd;
        logic [4:0]  ln;
        logic [7:0]  ss, ssn;
        logic [1:0]  eg;
        own = -1;
        for (int i = 1; i <= NREQ; i++) begin
            k = (m_last + i) % NREQ;
            if (own < 0 && v.req[k]) own = k;
        end
        if (v.exp_own >= 0) own = v.exp_own;
        m_last = own;
        if (v.exp_err >= 0) expe = (v.exp_err != 0);
        else expe = (v.dly < 0) || (v.dly >= WD_CYC);
        wd  = (own == 1) ? v.d1 : v.d0;
        ln  = (own == 1) ? v.l1 : v.l0;
        ss  = (own == 1) ? v.s1 : v.s0;
        ssn = ~ss;
        eg  = 2'b01 << own;
        i_req       = v.req;
        i_req_data  = {v.d1, v.d0};
        i_req_len   = {v.l1, v.l0};
        i_req_ss    = {v.s1, v.s0};
        i_lsb       = 1'($urandom);
        i_tip       = 1'b0;
        i_eng_rdata = $urandom;
        c = 0; gc = -1; goc = -1; dc = -1; ec = -1; rc = -1;
        rise = -1; fall = -1; endc = -1; ndone = 0; nerr = 0;
        ss_ok = 1'b1;
        while (rc < 0 && c < 300) begin
            @(negedge i_clk);
            c++;
            if (gc < 0 && o_gnt != 0) begin
                gc = c;
                chk("gnt", o_gnt, eg);
                chk("gnt_latency", gc, 1);
                chk("load_latch", o_latch, 4'b0001);
                chk("load_bsel", o_byte_sel, 4'hF);
                chk("load_wdata", o_eng_wdata, wd);
                chk("load_len", o_len, ln);
                chk("load_ss", o_ss_n, ssn);
                chk("lsb", o_lsb, i_lsb);
                chk("busy", o_busy, 1);
                i_req_data = {$urandom, $urandom};
                i_req_ss   = ~i_req_ss;
                i_req_len  = ~i_req_len;
            end
            if (gc >= 0 && goc < 0 && o_go) begin
                goc = c;
                chk("go_latency", goc, 2 + CS_SETUP);
                chk("go_wdata", o_eng_wdata, wd);
                chk("go_len", o_len, ln);
                chk("go_latch", o_latch, 0);
                if (v.dly >= 0) begin
                    rise = c + v.dly;
                    fall = rise + v.tl;
                end
            end
            if (o_done != 0) begin
                ndone++;
                if (dc < 0) begin
                    dc = c; endc = c;
                    chk("done_who", o_done, eg);
                    chk("done_time", c, fall + 2);
                    chk("done_rdata", o_rdata, v.echo);
                    m_rdata = v.echo;
                end
            end
            if (o_err != 0) begin
                nerr++;
                if (ec < 0) begin
                    ec = c; endc = c;
                    chk("err_who", o_err, eg);
                    chk("err_time", c, goc + WD_CYC);
                    chk("err_rdata", o_rdata, m_rdata);
                end
            end
            if (endc >= 0 && c > endc && !o_busy) begin
                rc = c;
                chk("ss_release_time", c, endc + CS_HOLD + 1);
                chk("ss_release", o_ss_n, 8'hFF);
            end else if (gc >= 0 && o_ss_n != ssn) begin
                ss_ok = 1'b0;
            end
            if (c == rise) i_tip = 1'b1;
            if (c == fall) begin
                i_tip       = 1'b0;
                i_eng_rdata = v.echo;
            end
            if (fall >= 0 && c == fall + 2) i_eng_rdata = $urandom;
        end
        if (rc < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL xfer_timeout: got no release after %0d cycles, required one", c);
        end
        chk("ss_held", ss_ok, 1);
        chk("done_count", ndone, expe ? 0 : 1);
        chk("err_count", nerr, expe ? 1 : 0);
        i_tip = 1'b0;
    endtask

    initial begin
        vec_t rv;
        bit   seen;
        n_vec = 0;
        n_bad = 0;
        m_last = NREQ - 1;
        m_rdata = '0;

        tbl[0]  = '{2'b01, 32'hA5A51234, 32'h0, 5'd8, 5'd0, 8'h01, 8'h00, 2, 8, 32'h0000003C, 0, 0};
        tbl[1]  = '{2'b11, 32'h11111111, 32'h22222222, 5'd16, 5'd24, 8'h02, 8'h04, 1, 5, 32'h1234ABCD, 1, 0};
        tbl[2]  = '{2'b11, 32'h33333333, 32'h44444444, 5'd7, 5'd12, 8'h08, 8'h10, 3, 4, 32'h55AA55AA, 0, 0};
        tbl[3]  = '{2'b11, 32'h55555555, 32'h66666666, 5'd1, 5'd31, 8'h20, 8'h40, 2, 2, 32'h87654321, 1, 0};
        tbl[4]  = '{2'b11, 32'h77777777, 32'h88888888, 5'd9, 5'd3, 8'h80, 8'h01, 4, 6, 32'h0F0F0F0F, 0, 0};
        tbl[5]  = '{2'b01, 32'hCAFEF00D, 32'h0, 5'd0, 5'd0, 8'h01, 8'h00, 2, 33, 32'hDEADBEEF, 0, 0};
        tbl[6]  = '{2'b10, 32'h0, 32'h13572468, 5'd8, 5'd8, 8'h00, 8'h02, -1, 0, 32'h0BADBAD0, 1, 1};
        tbl[7]  = '{2'b01, 32'h24681357, 32'h0, 5'd4, 5'd0, 8'h04, 8'h00, 0, 3, 32'h00C0FFEE, 0, 0};
        tbl[8]  = '{2'b11, 32'h9ABCDEF0, 32'hFEDCBA98, 5'd5, 5'd6, 8'h08, 8'h10, WD_CYC - 1, 4, 32'hA1B2C3D4, 1, 0};
        tbl[9]  = '{2'b11, 32'h01020304, 32'h05060708, 5'd2, 5'd3, 8'h20, 8'h40, WD_CYC, 4, 32'hEEEEEEEE, 0, 1};
        tbl[10] = '{2'b10, 32'h0, 32'hABCDEF01, 5'd8, 5'd10, 8'h00, 8'h00, 2, 3, 32'h5A5A5A5A, 1, 0};

        i_rst_n     = 1'b0;
        i_req       = '0;
        i_req_data  = '0;
        i_req_len   = '0;
        i_req_ss    = '0;
        i_lsb       = 1'b0;
        i_tip       = 1'b0;
        i_eng_rdata = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_ss", o_ss_n, 8'hFF);
        chk("rst_busy", o_busy, 0);
        chk("rst_go", o_go, 0);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_latch", o_latch, 0);
        chk("rst_rdata", o_rdata, 0);
        i_rst_n = 1'b1;

        // Reset while the engine is mid-transfer.
        i_req      = 2'b11;
        i_req_data = {32'h22220000, 32'h11110000};
        i_req_len  = {5'd9, 5'd8};
        i_req_ss   = {8'h02, 8'h01};
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge i_clk);
            if (o_go) seen = 1'b1;
        end
        chk("rst_test_go_seen", seen, 1);
        i_tip = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("pre_rst_busy", o_busy, 1);
        chk("pre_rst_ss", o_ss_n, 8'hFE);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_ss", o_ss_n, 8'hFF);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_wdata", o_eng_wdata, 0);
        chk("async_rst_len", o_len, 0);
        i_tip = 1'b0;
        @(negedge i_clk);
        chk("rst_no_done", o_done, 0);
        chk("rst_no_err", o_err, 0);
        i_rst_n = 1'b1;
        m_last  = NREQ - 1;
        m_rdata = '0;
        rv = '{2'b11, 32'h0A0A0A0A, 32'h0B0B0B0B, 5'd8, 5'd8, 8'h01, 8'h02, 2, 3, 32'h00000077, 0, 0};
        xfer(rv);

        for (int t = 0; t < 11; t++) xfer(tbl[t]);

        for (int r = 0; r < 30; r++) begin
            rv.req  = 2'($urandom_range(1, 3));
            rv.d0   = $urandom;
            rv.d1   = $urandom;
            rv.l0   = 5'($urandom);
            rv.l1   = 5'($urandom);
            rv.s0   = ($urandom_range(0, 8) == 8) ? 8'h00 : 8'h01 << $urandom_range(0, 7);
            rv.s1   = ($urandom_range(0, 8) == 8) ? 8'h00 : 8'h01 << $urandom_range(0, 7);
            rv.dly  = $urandom_range(0, WD_CYC + 2);
            rv.tl   = $urandom_range(2, 10);
            rv.echo = $urandom;
            rv.exp_own = -1;
            rv.exp_err = -1;
            xfer(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
